// File: rtl/warp_pkg.sv
// Shared constants, debug-visible state encoding and the in-flight tag type
// for the warp scheduler.
package warp_pkg;

    localparam int ELEMS        = 512;
    localparam int LANES        = 8;
    localparam int DATA_W       = 16;
    localparam int MAX_INFLIGHT = 4;
    localparam int CNT_W        = 10;
    localparam int GRP_W        = $clog2(ELEMS / LANES);
    localparam int LANE_W       = $clog2(LANES);
    localparam int GCNT_W       = GRP_W + 1;
    localparam int INF_W        = $clog2(MAX_INFLIGHT) + 1;
    localparam int TAG_W        = GRP_W + LANES;

    // One-hot so the value can drive GPIO_LED directly.
    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_ISSUE = 4'b0010;
    localparam logic [3:0] ST_DRAIN = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b1000;

    typedef struct packed {
        logic [GRP_W-1:0] addr;
        logic [LANES-1:0] mask;
    } tag_t;

    // Lanes populated in the final group: low rem bits, or all lanes when rem is 0.
    function automatic logic [LANES-1:0] tail_mask(input logic [LANE_W-1:0] rem);
        logic [LANES-1:0] m;
        if (rem == '0) begin
            m = '1;
        end else begin
            m = (LANES'(1) << rem) - LANES'(1);
        end
        return m;
    endfunction

endpackage

// File: rtl/warp_scheduler_if.sv
// Buffer and lane-array signals of the warp scheduler, bundled so the
// scheduler (master) and the surrounding datapath (slave) share one port.
interface warp_scheduler_if;
    import warp_pkg::*;

    // Read: in_rd_en with in_rd_addr returns in_rd_data one cycle later.
    // Issue: lane_ready high in cycle t means the group shown in t+1 is taken.
    // Return: lane_out_valid marks one whole group, in issue order, no stall.
    // Write: res_wr_en is a single-cycle strobe with addr, data and mask.
    logic                    in_rd_en;
    logic [GRP_W-1:0]        in_rd_addr;
    logic [LANES*DATA_W-1:0] in_rd_data;
    logic                    lane_ready;
    logic [LANES*DATA_W-1:0] lane_in_data;
    logic [LANES-1:0]        lane_in_valid;
    logic [LANES*DATA_W-1:0] lane_out_data;
    logic                    lane_out_valid;
    logic                    res_wr_en;
    logic [GRP_W-1:0]        res_wr_addr;
    logic [LANES*DATA_W-1:0] res_wr_data;
    logic [LANES-1:0]        res_wr_mask;

    modport master (
        output in_rd_en, in_rd_addr,
        input  in_rd_data,
        input  lane_ready,
        output lane_in_data, lane_in_valid,
        input  lane_out_data, lane_out_valid,
        output res_wr_en, res_wr_addr, res_wr_data, res_wr_mask
    );

    modport slave (
        input  in_rd_en, in_rd_addr,
        output in_rd_data,
        output lane_ready,
        input  lane_in_data, lane_in_valid,
        output lane_out_data, lane_out_valid,
        input  res_wr_en, res_wr_addr, res_wr_data, res_wr_mask
    );

endinterface

// File: rtl/warp_tag_fifo.sv
// Small synchronous FIFO holding {group index, lane mask} for each group
// issued to the lanes and not yet returned. DEPTH must be a power of two.
module warp_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Streams a batch of element groups from the batch buffer through a shared
// lane array and writes each returning group back to the result buffer.
module warp_scheduler
    import warp_pkg::*;
(
    input  logic             bus_clk,
    input  logic             bus_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [3:0]       dbg_state_o,
    warp_scheduler_if.master bus
);

    logic [3:0]              state_q, state_d;
    logic [GCNT_W-1:0]       groups_q, groups_d;
    logic [GCNT_W-1:0]       issued_q, issued_d;
    logic [LANES-1:0]        tail_q, tail_d;
    logic [INF_W-1:0]        inflight_q, inflight_d;
    logic                    error_q, error_d;
    logic                    lane_vld_q;
    logic [LANES-1:0]        lane_mask_q;
    logic                    wr_en_q;
    logic [GRP_W-1:0]        wr_addr_q;
    logic [LANES*DATA_W-1:0] wr_data_q;
    logic [LANES-1:0]        wr_mask_q;

    logic [CNT_W-1:0]        n_elems;
    logic [CNT_W:0]          n_round;
    logic [GCNT_W-1:0]       start_groups;
    logic                    is_issue;
    logic                    rd_en;
    logic                    pop;
    logic                    stray_busy;
    logic                    fifo_empty;
    logic                    fifo_full;
    tag_t                    push_tag;
    tag_t                    head_tag;

    assign n_elems      = (count > CNT_W'(ELEMS)) ? CNT_W'(ELEMS) : count;
    assign n_round      = {1'b0, n_elems} + (CNT_W+1)'(LANES - 1);
    assign start_groups = GCNT_W'(n_round >> LANE_W);

    assign is_issue = (state_q == ST_ISSUE);
    assign busy     = is_issue || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign error    = error_q;

    // Abort suppresses issue and return in its own cycle so nothing new is tracked.
    assign rd_en = is_issue && !abort && bus.lane_ready && !fifo_full
                && (issued_q < groups_q) && (inflight_q < INF_W'(MAX_INFLIGHT));
    assign pop        = bus.lane_out_valid && !fifo_empty && !abort;
    assign stray_busy = bus.lane_out_valid && fifo_empty && busy;

    assign push_tag.addr = issued_q[GRP_W-1:0];
    assign push_tag.mask = (issued_q == groups_q - GCNT_W'(1)) ? tail_q : '1;

    warp_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk_i   (bus_clk),
        .rst_ni  (bus_rst_n),
        .flush_i (abort),
        .push_i  (rd_en),
        .wdata_i (push_tag),
        .pop_i   (pop),
        .rdata_o (head_tag),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        groups_d   = groups_q;
        tail_d     = tail_q;
        issued_d   = issued_q + GCNT_W'(rd_en);
        inflight_d = inflight_q + INF_W'(rd_en) - INF_W'(pop);
        error_d    = error_q | stray_busy;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    groups_d   = start_groups;
                    tail_d     = tail_mask(n_elems[LANE_W-1:0]);
                    issued_d   = '0;
                    inflight_d = '0;
                    error_d    = 1'b0;
                    state_d    = (n_elems == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issued_q == groups_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last pop has already been registered into the write stage.
                if (inflight_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            issued_d   = '0;
            inflight_d = '0;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_q     <= ST_IDLE;
            groups_q    <= '0;
            issued_q    <= '0;
            tail_q      <= '0;
            inflight_q  <= '0;
            error_q     <= 1'b0;
            lane_vld_q  <= 1'b0;
            lane_mask_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_mask_q   <= '0;
        end else begin
            state_q    <= state_d;
            groups_q   <= groups_d;
            issued_q   <= issued_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
            error_q    <= error_d;
            lane_vld_q <= rd_en;
            if (rd_en) begin
                lane_mask_q <= push_tag.mask;
            end
            wr_en_q <= pop;
            if (pop) begin
                wr_addr_q <= head_tag.addr;
                wr_data_q <= bus.lane_out_data;
                wr_mask_q <= head_tag.mask;
            end
        end
    end

    // Read data arrives the cycle after the strobe and goes straight to the lanes.
    assign bus.in_rd_en      = rd_en;
    assign bus.in_rd_addr    = issued_q[GRP_W-1:0];
    assign bus.lane_in_data  = lane_vld_q ? bus.in_rd_data : '0;
    assign bus.lane_in_valid = lane_vld_q ? lane_mask_q : '0;
    assign bus.res_wr_en     = wr_en_q;
    assign bus.res_wr_addr   = wr_addr_q;
    assign bus.res_wr_data   = wr_data_q;
    assign bus.res_wr_mask   = wr_mask_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: batch buffer and fixed-latency kernel
// models, per-event scoreboards and hand-derived cycle/mask expectations.
module tb_warp_scheduler;
    import warp_pkg::*;

    localparam int CW = 160;
    localparam int DW = LANES * DATA_W;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } kent_t;

    logic             bus_clk = 1'b0;
    logic             bus_rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             busy;
    logic             done;
    logic             error;
    logic [3:0]       dbg_state;

    warp_scheduler_if bus();

    warp_scheduler dut (
        .bus_clk     (bus_clk),
        .bus_rst_n   (bus_rst_n),
        .start       (start),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .dbg_state_o (dbg_state),
        .bus         (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 bus_clk = ~bus_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 2;
    int ready_mode = 0;
    bit start_req = 0;
    bit abort_req = 0;
    bit stray_req = 0;
    logic [CNT_W-1:0] count_req = '0;
    logic             rd_pend = 1'b0;
    logic [GRP_W-1:0] rd_pend_addr = '0;
    logic [15:0]      seed = 16'h1234;
    int rd_cnt, wr_cnt, done_cnt, done_cyc, first_rd, last_rd, first_wr, last_wr;
    int outst, max_inf, start_cyc;

    kent_t kq[$];
    logic [GRP_W-1:0]            exp_rd_q[$];
    logic [LANES+DW-1:0]         exp_lv_q[$];
    logic [GRP_W+LANES+DW-1:0]   exp_q[$];

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [GRP_W-1:0] a);
        logic [DW-1:0] w;
        for (int j = 0; j < LANES; j++) begin
            w[j*DATA_W +: DATA_W] = 16'(int'(a) * LANES + j) ^ seed;
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] kern(input logic [DW-1:0] x);
        logic [DW-1:0] w;
        for (int j = 0; j < LANES; j++) begin
            w[j*DATA_W +: DATA_W] = x[j*DATA_W +: DATA_W] * 16'd3 + 16'h0101;
        end
        return w;
    endfunction

    // ---------------- driver / monitor ----------------
    // Called 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic tick();
        logic [GRP_W-1:0]          ea;
        logic [LANES+DW-1:0]       el;
        logic [GRP_W+LANES+DW-1:0] ew;
        start = start_req;
        abort = abort_req;
        count = count_req;
        start_req = 0;
        abort_req = 0;
        bus.in_rd_data = rd_pend ? mem_word(rd_pend_addr) : '0;
        case (ready_mode)
            0:       bus.lane_ready = 1'b1;
            1:       bus.lane_ready = 1'($urandom_range(0, 1));
            default: bus.lane_ready = 1'b0;
        endcase
        bus.lane_out_valid = 1'b0;
        bus.lane_out_data  = '0;
        if (stray_req) begin
            bus.lane_out_valid = 1'b1;
            bus.lane_out_data  = {8{16'hDEAD}};
            stray_req = 0;
        end else if (kq.size() > 0 && kq[0].due <= cyc) begin
            bus.lane_out_valid = 1'b1;
            bus.lane_out_data  = kq[0].data;
            void'(kq.pop_front());
        end
        #1;
        if (bus.in_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            outst++;
            if (outst > max_inf) max_inf = outst;
            if (exp_rd_q.size() > 0) begin
                ea = exp_rd_q.pop_front();
                check("rd_addr", CW'(bus.in_rd_addr), CW'(ea));
            end else begin
                check("rd_extra", CW'(bus.in_rd_en), CW'(0));
            end
        end
        rd_pend      = bus.in_rd_en;
        rd_pend_addr = bus.in_rd_addr;
        if (bus.lane_in_valid != '0) begin
            kq.push_back('{cyc + lat, kern(bus.lane_in_data)});
            if (exp_lv_q.size() > 0) begin
                el = exp_lv_q.pop_front();
                check("lane_in", CW'({bus.lane_in_valid, bus.lane_in_data}), CW'(el));
            end else begin
                check("lane_extra", CW'(bus.lane_in_valid), CW'(0));
            end
        end
        if (bus.lane_out_valid && outst > 0) outst--;
        if (bus.res_wr_en) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (exp_q.size() > 0) begin
                ew = exp_q.pop_front();
                check("res_wr", CW'({bus.res_wr_addr, bus.res_wr_mask, bus.res_wr_data}), CW'(ew));
            end else begin
                check("wr_extra", CW'(bus.res_wr_en), CW'(0));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge bus_clk);
        #1;
        cyc++;
    endtask

    task automatic clear_obs();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
        outst = 0; max_inf = 0;
        exp_rd_q.delete();
        exp_lv_q.delete();
        exp_q.delete();
    endtask

    // Loads the scoreboards for groups 0..grps-1 with the hand-given tail mask.
    task automatic load_exp(input int grps, input logic [LANES-1:0] tmask);
        logic [LANES-1:0] m;
        for (int g = 0; g < grps; g++) begin
            m = (g == grps - 1) ? tmask : 8'hFF;
            exp_rd_q.push_back(GRP_W'(g));
            exp_lv_q.push_back({m, mem_word(GRP_W'(g))});
            exp_q.push_back({GRP_W'(g), m, kern(mem_word(GRP_W'(g)))});
        end
    endtask

    task automatic run_batch(input int cnt, input int grps, input logic [LANES-1:0] tmask,
                             input int lat_i, input int rmode);
        seed = 16'($urandom_range(0, 65535));
        lat = lat_i;
        ready_mode = rmode;
        clear_obs();
        load_exp(grps, tmask);
        start_cyc = cyc;
        start_req = 1;
        count_req = CNT_W'(cnt);
        tick();
        check("err_clr_on_start", CW'(error), CW'(0));
        for (int i = 0; i < 1000 && done_cnt == 0; i++) tick();
        repeat (3) tick();
        check("done_once", CW'(done_cnt), CW'(1));
        check("rd_count", CW'(rd_cnt), CW'(grps));
        check("wr_count", CW'(wr_cnt), CW'(grps));
        check("wr_left", CW'(exp_q.size()), CW'(0));
        check("err_end", CW'(error), CW'(0));
        check("busy_end", CW'(busy), CW'(0));
        check("max_inflight", CW'(max_inf > MAX_INFLIGHT), CW'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.in_rd_data = '0;
        bus.lane_ready = 1'b0;
        bus.lane_out_valid = 1'b0;
        bus.lane_out_data = '0;
        clear_obs();
        repeat (3) @(posedge bus_clk);
        #1;
        check("rst_state", CW'(dbg_state), CW'(4'b0001));
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_done", CW'(done), CW'(0));
        check("rst_error", CW'(error), CW'(0));
        check("rst_rd_en", CW'(bus.in_rd_en), CW'(0));
        check("rst_rd_addr", CW'(bus.in_rd_addr), CW'(0));
        check("rst_lane_valid", CW'(bus.lane_in_valid), CW'(0));
        check("rst_lane_data", CW'(bus.lane_in_data), CW'(0));
        check("rst_wr_en", CW'(bus.res_wr_en), CW'(0));
        check("rst_wr_addr", CW'(bus.res_wr_addr), CW'(0));
        check("rst_wr_data", CW'(bus.res_wr_data), CW'(0));
        bus_rst_n = 1'b1;

        // Full batch, L=2: reads 1..64, writes 5..68, done at 69.
        run_batch(512, 64, 8'hFF, 2, 0);
        check("t1_first_rd", CW'(first_rd - start_cyc), CW'(1));
        check("t1_last_rd", CW'(last_rd - start_cyc), CW'(64));
        check("t1_first_wr", CW'(first_wr - start_cyc), CW'(5));
        check("t1_last_wr", CW'(last_wr - start_cyc), CW'(68));
        check("t1_done_cyc", CW'(done_cyc - start_cyc), CW'(69));

        // Partial tail groups.
        run_batch(13, 2, 8'h1F, 2, 0);
        check("t2_done_cyc", CW'(done_cyc - start_cyc), CW'(7));
        run_batch(9, 2, 8'h01, 3, 0);

        // Backpressure with a long kernel.
        run_batch(100, 13, 8'h0F, 5, 1);

        // Oversized count clamps to the full batch; L=1.
        run_batch(1023, 64, 8'hFF, 1, 0);
        check("t5_done_cyc", CW'(done_cyc - start_cyc), CW'(68));

        // Empty batch.
        run_batch(0, 0, 8'hFF, 2, 0);
        check("t6_done_cyc", CW'(done_cyc - start_cyc), CW'(1));

        // Abort after ten groups.
        seed = 16'h5A5A;
        lat = 3;
        ready_mode = 0;
        clear_obs();
        load_exp(64, 8'hFF);
        start_req = 1;
        count_req = CNT_W'(512);
        tick();
        for (int i = 0; i < 100 && rd_cnt < 10; i++) tick();
        abort_req = 1;
        tick();
        exp_rd_q.delete();
        exp_lv_q.delete();
        exp_q.delete();
        outst = 0;
        check("ab_state", CW'(dbg_state), CW'(4'b0001));
        check("ab_busy", CW'(busy), CW'(0));
        repeat (12) tick();
        check("ab_no_done", CW'(done_cnt), CW'(0));
        check("ab_late_err", CW'(error), CW'(0));
        check("ab_rd_cnt", CW'(rd_cnt), CW'(10));
        run_batch(37, 5, 8'h1F, 2, 0);

        // Stray return while idle is dropped silently.
        clear_obs();
        stray_req = 1;
        tick();
        repeat (2) tick();
        check("idle_stray_err", CW'(error), CW'(0));
        check("idle_stray_wr", CW'(wr_cnt), CW'(0));

        // Stray return while busy with nothing in flight.
        lat = 2;
        ready_mode = 2;
        clear_obs();
        start_req = 1;
        count_req = CNT_W'(8);
        tick();
        repeat (2) tick();
        check("er_busy", CW'(busy), CW'(1));
        stray_req = 1;
        tick();
        tick();
        check("er_set", CW'(error), CW'(1));
        check("er_no_wr", CW'(wr_cnt), CW'(0));
        abort_req = 1;
        tick();
        tick();
        check("er_sticky", CW'(error), CW'(1));
        run_batch(16, 2, 8'hFF, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Time-multiplexes a batch of up to ELEMS 16-bit elements across a shared array of LANES kernel lanes, replacing one-kernel-per-element replication. Sits between the receive-side batch buffer and the send-side result buffer of the PCIe demo datapath. It reads element groups, issues them to the lanes under backpressure, tracks in-flight groups, and writes returning results back by group index. A batch is started and aborted by the top-level session FSM.

## Interface
Parameters:
- ELEMS, 512, elements per batch (multiple of LANES)
- LANES, 8, kernel lanes, one element each per group
- DATA_W, 16, element width
- MAX_INFLIGHT, 4, maximum issued-but-unreturned groups (power of 2)

Ports. One clock; reset is asynchronous and active-low.
- bus_clk  in  1  clock
- bus_rst_n  in  1  asynchronous active-low reset
- start  in  1  begin batch; honoured only in IDLE
- abort  in  1  synchronous abandon (quiesce / file closed)
- count  in  10  elements in batch, latched on start
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse at batch completion
- error  out  1  sticky: result returned with no group in flight; cleared by start
- in_rd_en  out  1  batch buffer read strobe
- in_rd_addr  out  6  group index (log2(ELEMS/LANES))
- in_rd_data  in  LANES*DATA_W  read data, 1-cycle latency
- lane_ready  in  1  lanes accept the group presented next cycle
- lane_in_data  out  LANES*DATA_W  group to lanes
- lane_in_valid  out  LANES  per-lane element-valid mask
- lane_out_data  in  LANES*DATA_W  returned group
- lane_out_valid  in  1  whole-group result valid; groups return in issue order
- res_wr_en  out  1  result buffer write
- res_wr_addr  out  6  group index
- res_wr_data  out  LANES*DATA_W  result data
- res_wr_mask  out  LANES  per-lane write enable

## Operation
- States, one-hot: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on start.
  - Latch n = min(count, ELEMS).
  - Groups G = ceil(n/LANES).
  - Last-group mask = low (n mod LANES) bits set, or all ones if 0.
  - Clear error.
- start with n=0: IDLE -> DONE directly, no reads.
- ISSUE: in_rd_en = lane_ready && issued < G && inflight < MAX_INFLIGHT.
  - in_rd_addr = issued; issued increments on each read.
  - Push {addr, mask} into the tag FIFO; inflight increments.
- Cycle after in_rd_en: lane_in_data = in_rd_data and lane_in_valid = mask; otherwise lane_in_valid = 0.
- ISSUE -> DRAIN when issued == G.
- lane_out_valid with tag FIFO non-empty:
  - Pop the tag FIFO; inflight decrements.
  - Next cycle: res_wr_en=1, res_wr_addr=tag addr, res_wr_data=lane_out_data, res_wr_mask=tag mask.
- Same-cycle issue and return: inflight unchanged.
- DRAIN -> DONE when inflight == 0 and no write is pending.
- DONE: done=1 for one cycle, then IDLE.
- lane_out_valid with tag FIFO empty:
  - While busy: set error and drop the data.
  - While not busy: drop silently.
- abort in any state:
  - Next cycle state IDLE.
  - Counters and tag FIFO cleared; pending write cancelled; no done pulse.
  - abort takes priority over start.
- start outside IDLE is ignored.

## Timing
- Reset: state IDLE; all counters 0; busy, done, error, in_rd_en, lane_in_valid, res_wr_en = 0; address/data outputs 0.
- Latency:
  - start at cycle 0 -> first in_rd_en at cycle 1 (if lane_ready).
  - lane_in_valid at cycle 2.
  - Kernel latency L (from lane_in_valid to lane_out_valid) -> res_wr_en at cycle 2+L+1.
- Throughput: one group per cycle when lane_ready=1 and L+1 < MAX_INFLIGHT.
- done is asserted the cycle after the final res_wr_en.
- Backpressure: lane_ready=0 holds issue, and addresses do not advance; returns continue.

## Structure
- Package warp_pkg:
  - ELEMS, LANES, DATA_W, GRP_W = log2(ELEMS/LANES).
  - One-hot state constants, 4 bits, exported for GPIO_LED debug.
  - Tag type {GRP_W addr, LANES mask}.
- Sub-module warp_tag_fifo: synchronous FIFO, depth MAX_INFLIGHT, width GRP_W+LANES, with async active-low reset and synchronous flush.

## Test plan
- count=512, lane_ready=1, L=2 model, start at cycle 0:
  - in_rd_en cycles 1..64, addresses 0..63.
  - res_wr_en cycles 5..68, masks 0xFF.
  - done at cycle 69; error=0.
- count=13: G=2; lane_in_valid 0xFF then 0x1F; res_wr_mask 0xFF then 0x1F; one done.
- Random lane_ready toggling plus L=5:
  - inflight never exceeds 4.
  - Addresses strictly sequential; results written in order with matching data; single done.
- count=0: done one cycle after start; no in_rd_en or res_wr_en.
- abort during ISSUE after 10 groups:
  - IDLE next cycle; no done; busy=0.
  - Late lane_out_valid dropped with error=0.
  - New start runs cleanly.
- lane_out_valid while busy with empty tag FIFO: error=1, no res_wr_en; next start clears error.
